// File: rtl/lbm_pkg.sv
// Shared lattice-Boltzmann definitions: direction set and orderings, compass offsets,
// boundary modes and the opposite-direction table used by the reflecting consumer.
package lbm_pkg;

    typedef enum logic [3:0] {
        DIR_C  = 4'd0,
        DIR_N  = 4'd1,
        DIR_NE = 4'd2,
        DIR_E  = 4'd3,
        DIR_SE = 4'd4,
        DIR_S  = 4'd5,
        DIR_SW = 4'd6,
        DIR_W  = 4'd7,
        DIR_NW = 4'd8
    } dir_e;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_WALL     = 1'b1
    } mode_e;

    localparam dir_e D2Q9_ORDER [9] = '{DIR_C, DIR_N, DIR_NE, DIR_E, DIR_SE,
                                        DIR_S, DIR_SW, DIR_W, DIR_NW};
    localparam dir_e D2Q5_ORDER [5] = '{DIR_C, DIR_N, DIR_E, DIR_S, DIR_W};

    // North is y-1, east is x+1; indexed by dir_e.
    localparam int DIR_DX [9] = '{0,  0,  1, 1, 1, 0, -1, -1, -1};
    localparam int DIR_DY [9] = '{0, -1, -1, 0, 1, 1,  1,  0, -1};

    localparam dir_e DIR_OPPOSITE [9] = '{DIR_C, DIR_S, DIR_SW, DIR_W, DIR_NW,
                                          DIR_N, DIR_NE, DIR_E, DIR_SE};

    // Maps a BRAM/port index to its lattice direction for the chosen velocity set.
    function automatic dir_e dir_of(input int ndir, input int idx);
        if (ndir == 5) begin
            return D2Q5_ORDER[idx];
        end
        return D2Q9_ORDER[idx];
    endfunction

endpackage

// File: rtl/lbm_neighbor_calc.sv
// Neighbour address for one direction with periodic wrap or wall reflection.
// Purely combinational, no latency and no flow control of its own.
module lbm_neighbor_calc
    import lbm_pkg::*;
#(
    parameter int HPIXELS = 205,
    parameter int VPIXELS = 154,
    localparam int HOR_SIZE  = $clog2(HPIXELS),
    localparam int VERT_SIZE = $clog2(VPIXELS),
    localparam int BRAM_SIZE = $clog2(HPIXELS * VPIXELS)
) (
    input  logic [HOR_SIZE-1:0]  x,
    input  logic [VERT_SIZE-1:0] y,
    input  dir_e                 dir,
    input  mode_e                mode,
    output logic [BRAM_SIZE-1:0] addr,
    output logic                 wall
);

    int   nx;
    int   ny;
    logic oob;

    always_comb begin
        nx  = int'(x) + DIR_DX[dir];
        ny  = int'(y) + DIR_DY[dir];
        oob = (nx < 0) || (nx >= HPIXELS) || (ny < 0) || (ny >= VPIXELS);
        if (nx < 0) begin
            nx = HPIXELS - 1;
        end else if (nx >= HPIXELS) begin
            nx = 0;
        end
        if (ny < 0) begin
            ny = VPIXELS - 1;
        end else if (ny >= VPIXELS) begin
            ny = 0;
        end
        // A reflected population stays in its own cell; the consumer swaps the BRAM.
        if ((mode == MODE_WALL) && oob) begin
            addr = BRAM_SIZE'(int'(y) * HPIXELS + int'(x));
            wall = 1'b1;
        end else begin
            addr = BRAM_SIZE'(ny * HPIXELS + nx);
            wall = 1'b0;
        end
    end

endmodule

// File: rtl/lbm_stream_addr_gen.sv
// Streaming-step sequencer: raster read addresses, neighbour write addresses LATENCY advances later.
// Latency: busy/read one cycle after start; ready_in=0 freezes counters, outputs and delay line.
module lbm_stream_addr_gen
    import lbm_pkg::*;
#(
    parameter int HPIXELS = 205,
    parameter int VPIXELS = 154,
    parameter int LATENCY = 3,
    parameter int NDIR    = 9,
    localparam int HOR_SIZE  = $clog2(HPIXELS),
    localparam int VERT_SIZE = $clog2(VPIXELS),
    localparam int BRAM_SIZE = $clog2(HPIXELS * VPIXELS)
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            start_in,
    input  logic                            mode_in,
    input  logic                            ready_in,
    output logic [BRAM_SIZE-1:0]            rd_addr_out,
    output logic                            rd_valid_out,
    output logic [NDIR-1:0][BRAM_SIZE-1:0]  wr_addr_out,
    output logic [NDIR-1:0]                 wall_out,
    output logic                            wr_valid_out,
    output logic                            busy_out,
    output logic                            done_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                         state;
    mode_e                          mode;
    logic [HOR_SIZE-1:0]            x;
    logic [VERT_SIZE-1:0]           y;
    logic                           push_vld;
    logic                           last_cell;
    logic                           row_end;
    logic [NDIR-1:0][BRAM_SIZE-1:0] nb_addr;
    logic [NDIR-1:0]                nb_wall;

    logic [NDIR-1:0][BRAM_SIZE-1:0] stage_addr [LATENCY];
    logic [NDIR-1:0]                stage_wall [LATENCY];
    logic [LATENCY-1:0]             stage_vld;
    logic [LATENCY-1:0]             vld_shift;

    always_comb begin
        push_vld  = (state == ST_SCAN);
        row_end   = (x == HOR_SIZE'(HPIXELS - 1));
        last_cell = row_end && (y == VERT_SIZE'(VPIXELS - 1));
        // Valid pattern after the next advance; all-zero means the pipe drains this cycle.
        vld_shift = LATENCY'({stage_vld, push_vld});
    end

    for (genvar d = 0; d < NDIR; d++) begin : g_nb
        lbm_neighbor_calc #(
            .HPIXELS (HPIXELS),
            .VPIXELS (VPIXELS)
        ) u_nb (
            .x    (x),
            .y    (y),
            .dir  (dir_of(NDIR, d)),
            .mode (mode),
            .addr (nb_addr[d]),
            .wall (nb_wall[d])
        );
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= ST_IDLE;
            mode         <= MODE_PERIODIC;
            x            <= '0;
            y            <= '0;
            rd_addr_out  <= '0;
            rd_valid_out <= 1'b0;
            busy_out     <= 1'b0;
            done_out     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_out <= 1'b0;
                    if (start_in) begin
                        state        <= ST_SCAN;
                        mode         <= mode_e'(mode_in);
                        x            <= '0;
                        y            <= '0;
                        rd_addr_out  <= '0;
                        rd_valid_out <= 1'b1;
                        busy_out     <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (ready_in) begin
                        if (last_cell) begin
                            state        <= ST_DRAIN;
                            x            <= '0;
                            y            <= '0;
                            rd_addr_out  <= '0;
                            rd_valid_out <= 1'b0;
                        end else begin
                            rd_addr_out <= rd_addr_out + BRAM_SIZE'(1);
                            if (row_end) begin
                                x <= '0;
                                y <= y + VERT_SIZE'(1);
                            end else begin
                                x <= x + HOR_SIZE'(1);
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (ready_in && (vld_shift == '0)) begin
                        state    <= ST_DONE;
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    done_out <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stage_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stage_addr[i] <= '0;
                stage_wall[i] <= '0;
            end
        end else if (ready_in) begin
            stage_vld     <= vld_shift;
            stage_addr[0] <= nb_addr;
            stage_wall[0] <= nb_wall;
            for (int i = 1; i < LATENCY; i++) begin
                stage_addr[i] <= stage_addr[i-1];
                stage_wall[i] <= stage_wall[i-1];
            end
        end
    end

    assign wr_addr_out  = stage_addr[LATENCY-1];
    assign wall_out     = stage_wall[LATENCY-1];
    assign wr_valid_out = stage_vld[LATENCY-1];

endmodule

// File: tb/tb_lbm_stream_addr_gen.sv
// Bench for lbm_stream_addr_gen on a 4x3 lattice: lattice model scoreboard plus literal cycle checks.
module tb_lbm_stream_addr_gen;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int L  = 3;
    localparam int ND = 9;
    localparam int N  = H * V;

    logic            clk = 1'b0;
    logic            rst_in;
    logic            start_in;
    logic            mode_in;
    logic            ready_in;
    logic [3:0]      rd_addr_out;
    logic            rd_valid_out;
    logic [8:0][3:0] wr_addr_out;
    logic [8:0]      wall_out;
    logic            wr_valid_out;
    logic            busy_out;
    logic            done_out;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_idx   = 0;
    int wr_idx   = 0;
    int done_cnt = 0;
    bit model_mode = 1'b0;

    lbm_stream_addr_gen #(
        .HPIXELS (H),
        .VPIXELS (V),
        .LATENCY (L),
        .NDIR    (ND)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst_in),
        .start_in     (start_in),
        .mode_in      (mode_in),
        .ready_in     (ready_in),
        .rd_addr_out  (rd_addr_out),
        .rd_valid_out (rd_valid_out),
        .wr_addr_out  (wr_addr_out),
        .wall_out     (wall_out),
        .wr_valid_out (wr_valid_out),
        .busy_out     (busy_out),
        .done_out     (done_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {wall[8:0], addr[8:0][3:0]} for cell c, straight from the lattice rules.
    function automatic logic [63:0] model_wr(input int c, input bit wall_mode);
        int dxm [9] = '{0,  0,  1, 1, 1, 0, -1, -1, -1};
        int dym [9] = '{0, -1, -1, 0, 1, 1,  1,  0, -1};
        logic [8:0][3:0] a;
        logic [8:0]      w;
        int cx, cy, nx, ny;
        bit off;
        if (c >= N) return '1;
        cx = c % H;
        cy = c / H;
        for (int d = 0; d < 9; d++) begin
            nx  = cx + dxm[d];
            ny  = cy + dym[d];
            off = (nx < 0) || (nx >= H) || (ny < 0) || (ny >= V);
            if (wall_mode && off) begin
                a[d] = 4'(c);
                w[d] = 1'b1;
            end else begin
                a[d] = 4'(((ny + V) % V) * H + (nx + H) % H);
                w[d] = 1'b0;
            end
        end
        return 64'({w, a});
    endfunction

    always @(negedge clk) begin
        if (!rst_in) begin
            if (done_out) done_cnt++;
            if (rd_valid_out && ready_in) begin
                check("rd_addr_stream", 64'(rd_addr_out), 64'(rd_idx));
                rd_idx++;
            end
            if (wr_valid_out && ready_in) begin
                check("wr_stream", 64'({wall_out, wr_addr_out}), model_wr(wr_idx, model_mode));
                wr_idx++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the first busy cycle.
    task automatic start_sweep(input bit m);
        rd_idx     = 0;
        wr_idx     = 0;
        done_cnt   = 0;
        model_mode = m;
        mode_in    = m;
        start_in   = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        mode_in  = ~m;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done_and_count(input string tag);
        int i;
        for (i = 0; i < 200; i++) begin
            if (done_out) break;
            @(posedge clk); #1;
        end
        check({tag, "_done_seen"}, 64'(i < 200), 64'd1);
        @(negedge clk);
        #1;
        check({tag, "_reads"}, 64'(rd_idx), 64'(N));
        check({tag, "_writes"}, 64'(wr_idx), 64'(N));
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int p1 [9] = '{0, 8, 9, 1, 5, 4, 7, 3, 11};
        int p2 [9] = '{0, 0, 0, 1, 5, 4, 0, 0, 0};
        logic [8:0][3:0] e1;
        logic [8:0][3:0] e2;
        logic [3:0] flags;
        for (int d = 0; d < 9; d++) begin
            e1[d] = 4'(p1[d]);
            e2[d] = 4'(p2[d]);
        end

        rst_in   = 1'b1;
        start_in = 1'b0;
        mode_in  = 1'b0;
        ready_in = 1'b1;
        step(3);
        check("reset_outputs",
              64'({rd_valid_out, wr_valid_out, busy_out, done_out, rd_addr_out, wr_addr_out, wall_out}),
              64'd0);
        rst_in = 1'b0;
        step(1);

        // Periodic sweep with exact cycle timing; start during cycle 0.
        start_sweep(1'b0);
        for (int k = 1; k <= 17; k++) begin
            flags = {(k >= 1 && k <= 12), (k >= 4 && k <= 15), (k == 16), (k >= 1 && k <= 15)};
            check($sformatf("timing_c%0d", k),
                  64'({rd_valid_out, wr_valid_out, done_out, busy_out}), 64'(flags));
            if (k >= 1 && k <= 12) check($sformatf("rd_addr_c%0d", k), 64'(rd_addr_out), 64'(k - 1));
            if (k == 4) check("periodic_cell0", 64'({wall_out, wr_addr_out}), 64'({9'b0, e1}));
            if (k < 17) step(1);
        end
        check("periodic_done_pulses", 64'(done_cnt), 64'd1);

        // Back-to-back wall-mode sweep, start in the cycle after done.
        start_sweep(1'b1);
        check("b2b_busy", 64'(busy_out), 64'd1);
        step(3);
        check("wall_cell0", 64'({wall_out, wr_addr_out}), 64'({9'b111000110, e2}));
        wait_done_and_count("wall");

        // Five-cycle stall while cell 4 is being read and cell 1 written.
        start_sweep(1'b0);
        step(4);
        ready_in = 1'b0;
        for (int s = 0; s < 5; s++) begin
            check("stall_rd_addr", 64'(rd_addr_out), 64'd4);
            check("stall_wr_vld_e", 64'({wr_valid_out, wr_addr_out[3], busy_out}), 64'({1'b1, 4'd2, 1'b1}));
            step(1);
        end
        ready_in = 1'b1;
        wait_done_and_count("stall");

        // Reset during cycle 6 of a sweep.
        start_sweep(1'b1);
        step(5);
        rst_in = 1'b1;
        step(1);
        check("midsweep_reset",
              64'({rd_valid_out, wr_valid_out, busy_out, done_out, rd_addr_out, wr_addr_out, wall_out}),
              64'd0);
        rst_in = 1'b0;
        rd_idx = 0;
        wr_idx = 0;
        step(20);
        check("reset_no_done", 64'({done_cnt, busy_out}), 64'd0);
        start_sweep(1'b0);
        wait_done_and_count("post_reset");

        // Extra start while busy must not restart or extend the sweep.
        start_sweep(1'b0);
        step(2);
        start_in = 1'b1;
        step(1);
        start_in = 1'b0;
        wait_done_and_count("busy_start");
        step(3);
        check("busy_start_idle", 64'({busy_out, done_cnt}), 64'({1'b0, 32'd1}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lbm_stream_addr_gen.md
# lbm_stream_addr_gen

Parametrised address sequencer for the lattice-Boltzmann streaming step. On `start_in` it raster-scans the HPIXELS×VPIXELS lattice and issues one cell read address per advance. After a LATENCY-deep advance-gated delay, it issues the per-direction neighbour write addresses. Two boundary modes are supported: periodic wrap and solid-wall bounce-back. The block sits between the collision controller and the NDIR distribution BRAMs, and replaces hand-timed read-to-write address delays.

## Interface
Parameters:
- HPIXELS, 205, lattice width
- VPIXELS, 154, lattice height
- LATENCY, 3, advances between a read issue and the matching write issue (≥1)
- NDIR, 9, number of directions: 9 (D2Q9) or 5 (D2Q5)

Ports:
- clk_in  input  1  clock; one clock domain
- rst_in  input  1  reset, synchronous, active-high
- start_in  input  1  begins a sweep when idle
- mode_in  input  1  0 = periodic, 1 = wall; sampled at start
- ready_in  input  1  downstream can advance this cycle
- rd_addr_out  output  BRAM_SIZE  current cell address, shared by all BRAMs
- rd_valid_out  output  1  rd_addr_out valid
- wr_addr_out  output  [NDIR][BRAM_SIZE]  write address per direction
- wall_out  output  [NDIR]  bit d set means direction d was reflected
- wr_valid_out  output  1  wr_addr_out / wall_out valid
- busy_out  output  1  sweep in progress
- done_out  output  1  one-cycle pulse at sweep end

## Operation
- Derived widths: HOR_SIZE=$clog2(HPIXELS), VERT_SIZE=$clog2(VPIXELS), BRAM_SIZE=$clog2(HPIXELS*VPIXELS).
- Address formula: addr = y*HPIXELS + x.
- Direction order for D2Q9: 0 C, 1 N, 2 NE, 3 E, 4 SE, 5 S, 6 SW, 7 W, 8 NW.
- Direction order for D2Q5: 0 C, 1 N, 2 E, 3 S, 4 W.
- Compass conventions: N is y−1, E is x+1.
- States:
  - IDLE: start_in moves to SCAN at (0,0) and latches the mode.
  - SCAN: on each cycle with ready_in=1, x increments. At x=HPIXELS−1, x wraps to 0 and y increments. At the last cell (HPIXELS−1, VPIXELS−1), the state moves to DRAIN.
  - DRAIN: lasts until the delay line is empty, then goes to DONE.
  - DONE: lasts one cycle; done_out=1; then returns to IDLE.
- Read side: rd_valid_out=1 throughout SCAN. An advance is any cycle with ready_in=1. A cycle with ready_in=0 freezes the scan counters, all outputs and the delay line.
- Write side: the neighbour of (x,y) in direction d is computed at read issue and delayed LATENCY advances. This includes advances taken during DRAIN.
- Periodic mode: out-of-range coordinates wrap (−1→max, max+1→0); wall_out=0.
- Wall mode: for an out-of-range neighbour, wr_addr_out[d] is the cell's own address and wall_out[d]=1. The consumer writes that cell into the opposite-direction BRAM. In-range neighbours are computed as in periodic mode.
- Direction 0 always returns its own address, with wall_out[0]=0.
- start_in is ignored while busy_out=1.
- mode_in changes mid-sweep have no effect.

## Timing
- Reset values: rd_valid_out=0, wr_valid_out=0, busy_out=0, done_out=0, rd_addr_out=0, wr_addr_out=0, wall_out=0. State goes to IDLE, counters to 0, delay line empty.
- Reset mid-sweep aborts immediately; no done_out pulse is produced.
- start at cycle T gives busy_out=1 and rd_valid_out=1 at T+1.
- With ready_in held high:
  - The write for the first cell appears at T+1+LATENCY.
  - The last write appears at T+N+LATENCY, where N=HPIXELS*VPIXELS.
  - done_out fires at T+N+LATENCY+1, and busy_out falls in the same cycle.
- Back-to-back starts are allowed: start is accepted in the cycle after done_out.

## Structure
- Shared package lbm_pkg holds:
  - the direction enum and its D2Q9/D2Q5 orderings
  - dx/dy offset constants per direction
  - the boundary-mode enum
  - opposite-direction table
- Sub-module lbm_neighbor_calc: combinational; takes (x, y, d, mode) and returns (addr, wall). It is instantiated NDIR times.
- Delay line: LATENCY-entry shift register with a valid bit per stage, advanced only on ready_in.

## Test plan
Defaults for all scenarios: HPIXELS=4, VPIXELS=3, LATENCY=3, NDIR=9.
1. Periodic, cell (0,0) → wr_addr_out[0..8] = {0, 8, 9, 1, 5, 4, 7, 3, 11}; wall_out=0.
2. Wall mode, cell (0,0) → wall_out=9'b111000110; reflected directions give addr 0; E=1, SE=5, S=4.
3. Full sweep, ready_in=1, start at cycle 0 → rd_valid_out high for cycles 1–12 (addresses 0..11); wr_valid_out high for cycles 4–15; done_out at cycle 16 only.
4. ready_in=0 for 5 cycles mid-sweep → all outputs frozen; no address skipped or duplicated; 12 writes total.
5. rst_in asserted at cycle 6 of a sweep → next cycle all outputs 0; no done_out; a new start yields a clean sweep from address 0.
6. start_in pulsed while busy_out=1 → ignored; the sweep completes with exactly 12 writes and one done_out.
